// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock.
// Runs the multi-cycle DIV/DIVU path. busy_o is high while iterating and
// done_o pulses for one cycle when quotient_o/remainder_o are valid.
// Optional feature macro: SIGNED_DIV_EN adds the signed_i port and
// signed (truncate toward zero) division via magnitude divide + fix-up.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
`ifdef SIGNED_DIV_EN
  input  logic             signed_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  // dvd_q shifts the dividend out of its top while quotient bits enter at the bottom
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic             sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] diff, rem_next, dvd_next, q_fin, r_fin;

`ifdef SIGNED_DIV_EN
  assign sgn = signed_i;
`else
  assign sgn = 1'b0;
`endif

  // Operand magnitudes for a new request; the most negative value maps to
  // its own unsigned bit pattern, which is exactly its magnitude.
  always_comb begin
    a_neg = sgn & dividend_i[WIDTH-1];
    b_neg = sgn & divisor_i[WIDTH-1];
    a_mag = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    b_mag = b_neg ? (~divisor_i + 1'b1) : divisor_i;
  end

  // One restoring step; the trial compare keeps the bit shifted out of rem
  // so divisors above 2^(WIDTH-1) are handled without overflow.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, dsr_q});
    diff     = shifted[WIDTH-1:0] - dsr_q;
    rem_next = ge ? diff : shifted[WIDTH-1:0];
    dvd_next = {dvd_q[WIDTH-2:0], ge};
    q_fin    = q_neg_q ? (~dvd_next + 1'b1) : dvd_next;
    r_fin    = r_neg_q ? (~rem_next + 1'b1) : rem_next;
  end

  // Next-state and datapath updates; results register only on DONE entry.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend_i;
            div_zero_d  = 1'b1;
          end else begin
            state_d = CALC;
            count_d = '0;
            dvd_d   = a_mag;
            dsr_d   = b_mag;
            rem_d   = '0;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        dvd_d   = dvd_next;
        rem_d   = rem_next;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d     = DONE;
          quotient_d  = q_fin;
          remainder_d = r_fin;
          div_zero_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
    end
  end

  assign busy_o      = (state_q == CALC);
  assign done_o      = (state_q == DONE);
  assign div_zero_o  = div_zero_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors for seq_divider (WIDTH=32) with an
// arithmetic reference model compared against the outputs every cycle.
// Define SIGNED_DIV_EN to also exercise the signed port.
module tb_seq_divider;

  localparam int WIDTH = 32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
`ifdef SIGNED_DIV_EN
  logic        signed_r;
`endif
  logic        busy_o, done_o, div_zero_o;
  logic [31:0] quotient_o, remainder_o;

  int tests_run = 0;
  int tests_failed = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
`ifdef SIGNED_DIV_EN
    .signed_i    (signed_r),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .div_zero_o  (div_zero_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point shared by the directed checks and the model compare
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Arithmetic reference: returns {quotient, remainder, div_zero}
  function automatic logic [64:0] modelDivide(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic sgn);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'h0) return {32'hFFFF_FFFF, a, 1'b1};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return {32'h8000_0000, 32'h0, 1'b0};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sq, sr, 1'b0};
    end
    return {a / b, a % b, 1'b0};
  endfunction

  logic sgn_eff;
`ifdef SIGNED_DIV_EN
  assign sgn_eff = signed_r;
`else
  assign sgn_eff = 1'b0;
`endif

  // Reference timing: a non-zero divide publishes WIDTH edges after
  // acceptance, divide-by-zero publishes at the accepting edge.
  int          m_state = 0;
  int          m_left = 0;
  logic [64:0] m_pend = '0;
  logic [31:0] m_q = '0, m_r = '0;
  logic        m_dz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0;
      m_left  <= 0;
      m_q     <= '0;
      m_r     <= '0;
      m_dz    <= 1'b0;
    end else if (m_state != 1 && start) begin
      if (divisor == 32'h0) begin
        m_q     <= 32'hFFFF_FFFF;
        m_r     <= dividend;
        m_dz    <= 1'b1;
        m_state <= 2;
      end else begin
        m_pend  <= modelDivide(dividend, divisor, sgn_eff);
        m_left  <= WIDTH;
        m_state <= 1;
      end
    end else if (m_state == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_q     <= m_pend[64:33];
        m_r     <= m_pend[32:1];
        m_dz    <= m_pend[0];
        m_state <= 2;
      end
    end else begin
      m_state <= 0;
    end
  end

  // Compare every output against the reference on each falling edge
  always @(negedge clk) begin
    checkOutput("busy", {31'b0, busy_o}, {31'b0, m_state == 1});
    checkOutput("done", {31'b0, done_o}, {31'b0, m_state == 2});
    checkOutput("div_zero", {31'b0, div_zero_o}, {31'b0, m_dz});
    checkOutput("quotient", quotient_o, m_q);
    checkOutput("remainder", remainder_o, m_r);
  end

  // Wait for done_o with a bounded budget; lat counts edges after acceptance
  task automatic waitDone(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (done_o !== 1'b1 && lat < 200) begin
      if (busy_o) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) checkOutput("done_timeout", {31'b0, done_o}, 32'h1);
  endtask

  // Issue one request from a falling edge and return in its done cycle
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic sgn, output int lat,
                               output int busy_cnt);
    dividend = a;
    divisor  = b;
`ifdef SIGNED_DIV_EN
    signed_r = sgn;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, busy_cnt);
  endtask

  int lat, bc;

  initial begin
    rst = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
`ifdef SIGNED_DIV_EN
    signed_r = 1'b0;
`endif
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("reset_q", quotient_o, 32'h0);
    checkOutput("reset_r", remainder_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // 100/7: 32-cycle latency, busy for 32 cycles
    applyStimulus(32'd100, 32'd7, 1'b0, lat, bc);
    checkOutput("t1_latency", lat, 32'd32);
    checkOutput("t1_busy_cycles", bc, 32'd32);
    checkOutput("t1_q", quotient_o, 32'd14);
    checkOutput("t1_r", remainder_o, 32'd2);
    checkOutput("t1_dz", {31'b0, div_zero_o}, 32'h0);
    @(negedge clk);

    // All-ones by one, then divide by zero
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, lat, bc);
    checkOutput("t2_q", quotient_o, 32'hFFFF_FFFF);
    checkOutput("t2_r", remainder_o, 32'h0);
    @(negedge clk);
    applyStimulus(32'h1234, 32'd0, 1'b0, lat, bc);
    checkOutput("t2_dz_latency", lat, 32'd0);
    checkOutput("t2_dz_busy", bc, 32'd0);
    checkOutput("t2_dz_q", quotient_o, 32'hFFFF_FFFF);
    checkOutput("t2_dz_r", remainder_o, 32'h1234);
    checkOutput("t2_dz_flag", {31'b0, div_zero_o}, 32'h1);
    @(negedge clk);

    // Start pulse while busy is ignored
    dividend = 32'd100;
    divisor  = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, bc);
    checkOutput("t3_q", quotient_o, 32'd14);
    checkOutput("t3_r", remainder_o, 32'd2);
    checkOutput("t3_dz_cleared", {31'b0, div_zero_o}, 32'h0);
    @(negedge clk);

    // Reset in the middle of an operation
    dividend = 32'd1000;
    divisor  = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t4_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("t4_done", {31'b0, done_o}, 32'h0);
    checkOutput("t4_q", quotient_o, 32'h0);
    checkOutput("t4_r", remainder_o, 32'h0);
    checkOutput("t4_dz", {31'b0, div_zero_o}, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checkOutput("t4_no_done", {31'b0, done_o}, 32'h0);
    end
    applyStimulus(32'd9, 32'd4, 1'b0, lat, bc);
    checkOutput("t4_q2", quotient_o, 32'd2);
    checkOutput("t4_r2", remainder_o, 32'd1);
    @(negedge clk);

    // Back-to-back start accepted in the DONE cycle
    applyStimulus(32'd100, 32'd7, 1'b0, lat, bc);
    dividend = 32'd81;
    divisor  = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t5_busy", {31'b0, busy_o}, 32'h1);
    checkOutput("t5_q_held", quotient_o, 32'd14);
    checkOutput("t5_r_held", remainder_o, 32'd2);
    waitDone(lat, bc);
    checkOutput("t5_latency", lat, 32'd32);
    checkOutput("t5_q", quotient_o, 32'd9);
    checkOutput("t5_r", remainder_o, 32'd0);
    @(negedge clk);

    // Divisors with the top bit set and a dividend smaller than the divisor
    applyStimulus(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, lat, bc);
    checkOutput("big_q", quotient_o, 32'd1);
    checkOutput("big_r", remainder_o, 32'h7FFF_FFFE);
    @(negedge clk);
    applyStimulus(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, lat, bc);
    checkOutput("near_q", quotient_o, 32'd0);
    checkOutput("near_r", remainder_o, 32'hFFFF_FFFE);
    @(negedge clk);
    applyStimulus(32'd5, 32'd10, 1'b0, lat, bc);
    checkOutput("small_q", quotient_o, 32'd0);
    checkOutput("small_r", remainder_o, 32'd5);
    @(negedge clk);

`ifdef SIGNED_DIV_EN
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bc);
    checkOutput("s_neg_q", quotient_o, 32'hFFFF_FFFD);
    checkOutput("s_neg_r", remainder_o, 32'hFFFF_FFFF);
    checkOutput("s_latency", lat, 32'd32);
    @(negedge clk);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, lat, bc);
    checkOutput("s_dneg_q", quotient_o, 32'hFFFF_FFFD);
    checkOutput("s_dneg_r", remainder_o, 32'd1);
    @(negedge clk);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bc);
    checkOutput("s_min_q", quotient_o, 32'h8000_0000);
    checkOutput("s_min_r", remainder_o, 32'd0);
    @(negedge clk);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b0, lat, bc);
    checkOutput("s_uns_q", quotient_o, 32'h7FFF_FFFC);
    checkOutput("s_uns_r", remainder_o, 32'd1);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
